mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory port between the core (fetch + load/store)
//  and an auxiliary requester (boot loader / debug DMA). Per-cycle arbitration, one-cycle grant

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the core and aux command/response channels and the shared
// memory port of mem_arbiter.
//   core_* / aux_* : command (req, we, addr, wdata, funct3), gnt pulse, read response
//   aux_lock       : aux asks for exclusive ownership across a multi-beat burst
//   mem_*          : single unified memory port (wren, addr, wdata, funct3 out; rdata in)
// Modports: slave = arbiter side, master = requesters + memory side.
interface mem_arbiter_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned F3_W = 3;

    logic            core_req;
    logic            core_we;
    logic [XLEN-1:0] core_addr;
    logic [XLEN-1:0] core_wdata;
    logic [F3_W-1:0] core_funct3;
    logic            core_gnt;
    logic            core_rvalid;
    logic [XLEN-1:0] core_rdata;

    logic            aux_req;
    logic            aux_we;
    logic [XLEN-1:0] aux_addr;
    logic [XLEN-1:0] aux_wdata;
    logic [F3_W-1:0] aux_funct3;
    logic            aux_lock;
    logic            aux_gnt;
    logic            aux_rvalid;
    logic [XLEN-1:0] aux_rdata;

    logic            mem_wren;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [F3_W-1:0] mem_funct3;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_funct3,
        output core_gnt, core_rvalid, core_rdata,
        input  aux_req, aux_we, aux_addr, aux_wdata, aux_funct3, aux_lock,
        output aux_gnt, aux_rvalid, aux_rdata,
        output mem_wren, mem_addr, mem_wdata, mem_funct3,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_funct3,
        input  core_gnt, core_rvalid, core_rdata,
        output aux_req, aux_we, aux_addr, aux_wdata, aux_funct3, aux_lock,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  mem_wren, mem_addr, mem_wdata, mem_funct3,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: per-cycle arbiter sharing one unified instruction/data memory port between
// the core and an auxiliary requester (boot loader / debug DMA).
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : mem_arbiter_if.slave (core/aux command + response channels, memory port)
// Grant and memory command are combinational on the current requests; read data is routed
// back to the issuing requester in the cycle after issue (clocked memory read latency).
module mem_arbiter #(
    parameter bit          AUX_PRIORITY = 1'b0,
    parameter int unsigned MAX_WAIT     = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_AUX  = 2'd2
    } owner_e;

    owner_e            winner_c;
    owner_e            last_winner_q, last_winner_d;
    owner_e            resp_owner_q, resp_owner_d;
    logic              lock_q, lock_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [XLEN-1:0]   core_rdata_q, core_rdata_d;
    logic [XLEN-1:0]   aux_rdata_q, aux_rdata_d;
    logic              win_we_c;

    // Winner selection; nothing is granted while reset is asserted.
    always_comb begin
        winner_c = OWN_NONE;
        if (!reset) begin
            if (bus.core_req && bus.aux_req) begin
                if (lock_q) begin
                    winner_c = OWN_AUX;
                end else if (AUX_PRIORITY == 1'b0) begin
                    winner_c = (last_winner_q == OWN_AUX) ? OWN_CORE : OWN_AUX;
                end else begin
                    // Starvation guard: core wins once it has lost MAX_WAIT times in a row.
                    winner_c = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? OWN_CORE : OWN_AUX;
                end
            end else if (bus.core_req) begin
                winner_c = OWN_CORE;
            end else if (bus.aux_req) begin
                winner_c = OWN_AUX;
            end
        end
    end

    // Grant pulse and memory command mux.
    always_comb begin
        bus.core_gnt   = 1'b0;
        bus.aux_gnt    = 1'b0;
        bus.mem_wren   = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_funct3 = 3'b010;
        win_we_c       = 1'b0;
        case (winner_c)
            OWN_CORE: begin
                bus.core_gnt   = 1'b1;
                win_we_c       = bus.core_we;
                bus.mem_wren   = bus.core_we;
                bus.mem_addr   = bus.core_addr;
                bus.mem_wdata  = bus.core_wdata;
                bus.mem_funct3 = bus.core_funct3;
            end
            OWN_AUX: begin
                bus.aux_gnt    = 1'b1;
                win_we_c       = bus.aux_we;
                bus.mem_wren   = bus.aux_we;
                bus.mem_addr   = bus.aux_addr;
                bus.mem_wdata  = bus.aux_wdata;
                bus.mem_funct3 = bus.aux_funct3;
            end
            default: ;
        endcase
    end

    // Read response routing: owner sees live memory data, the other holds its last value.
    always_comb begin
        bus.core_rvalid = (resp_owner_q == OWN_CORE);
        bus.aux_rvalid  = (resp_owner_q == OWN_AUX);
        core_rdata_d    = bus.core_rvalid ? bus.mem_rdata : core_rdata_q;
        aux_rdata_d     = bus.aux_rvalid  ? bus.mem_rdata : aux_rdata_q;
        bus.core_rdata  = core_rdata_d;
        bus.aux_rdata   = aux_rdata_d;
    end

    // Next-state for arbitration history, lock and starvation counter.
    always_comb begin
        last_winner_d = last_winner_q;
        resp_owner_d  = OWN_NONE;
        lock_d        = 1'b0;
        wait_cnt_d    = '0;
        if (winner_c != OWN_NONE) begin
            last_winner_d = winner_c;
            if (!win_we_c) begin
                resp_owner_d = winner_c;
            end
        end
        // Lock only survives while aux keeps being granted with aux_lock high.
        lock_d = (winner_c == OWN_AUX) && bus.aux_lock;
        if (bus.core_req && (winner_c != OWN_CORE)) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_winner_q <= OWN_AUX;
            resp_owner_q  <= OWN_NONE;
            lock_q        <= 1'b0;
            wait_cnt_q    <= '0;
            core_rdata_q  <= '0;
            aux_rdata_q   <= '0;
        end else begin
            last_winner_q <= last_winner_d;
            resp_owner_q  <= resp_owner_d;
            lock_q        <= lock_d;
            wait_cnt_q    <= wait_cnt_d;
            core_rdata_q  <= core_rdata_d;
            aux_rdata_q   <= aux_rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Stimulus pushes expected grants and
// read responses into queues; a negedge monitor pops and compares whenever a DUT presents
// a gnt or rvalid. u_arb is round-robin with a small memory model, u_pri is aux-priority
// with MAX_WAIT=3.
module tb_mem_arbiter;
    typedef struct {
        bit          aux;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        bit          aux;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if ba ();
    mem_arbiter_if bp ();

    mem_arbiter #(.AUX_PRIORITY(1'b0), .MAX_WAIT(8)) u_arb (.clk(clk), .reset(rst), .bus(ba));
    mem_arbiter #(.AUX_PRIORITY(1'b1), .MAX_WAIT(3)) u_pri (.clk(clk), .reset(rst), .bus(bp));

    gnt_t gq[$];
    rsp_t rq[$];
    bit   pq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Clocked-read memory model behind u_arb.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (ba.mem_wren) mem[ba.mem_addr[7:2]] <= ba.mem_wdata;
        ba.mem_rdata <= mem[ba.mem_addr[7:2]];
    end
    assign bp.mem_rdata = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    task automatic drv_core(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        ba.core_req    = req;
        ba.core_we     = we;
        ba.core_addr   = addr;
        ba.core_wdata  = wdata;
        ba.core_funct3 = 3'b010;
    endtask

    task automatic drv_aux(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit lock);
        ba.aux_req    = req;
        ba.aux_we     = we;
        ba.aux_addr   = addr;
        ba.aux_wdata  = wdata;
        ba.aux_funct3 = 3'b010;
        ba.aux_lock   = lock;
    endtask

    task automatic exp_gnt(input bit aux, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        gnt_t g;
        g.aux = aux; g.we = we; g.addr = addr; g.wdata = wdata;
        gq.push_back(g);
    endtask

    task automatic exp_rd(input bit aux, input logic [31:0] data);
        rsp_t r;
        r.aux = aux; r.data = data;
        rq.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    gnt_t        mg;
    rsp_t        mr;
    bit          mb;
    logic [31:0] mdata;
    always @(negedge clk) begin
        if (ba.core_gnt || ba.aux_gnt) begin
            n_vec++;
            if (gq.size() == 0) begin
                n_bad++;
                $display("FAIL grant_unexpected: core_gnt=%0b aux_gnt=%0b addr=0x%08h, required no grant",
                         ba.core_gnt, ba.aux_gnt, ba.mem_addr);
            end else begin
                mg = gq.pop_front();
                if (ba.aux_gnt !== mg.aux || ba.core_gnt !== !mg.aux || ba.mem_wren !== mg.we ||
                    ba.mem_addr !== mg.addr || (mg.we && ba.mem_wdata !== mg.wdata)) begin
                    n_bad++;
                    $display("FAIL grant: got core=%0b aux=%0b wren=%0b addr=0x%08h wdata=0x%08h, expected aux=%0b we=%0b addr=0x%08h wdata=0x%08h",
                             ba.core_gnt, ba.aux_gnt, ba.mem_wren, ba.mem_addr, ba.mem_wdata,
                             mg.aux, mg.we, mg.addr, mg.wdata);
                end
            end
        end
        if (ba.core_rvalid || ba.aux_rvalid) begin
            n_vec++;
            mdata = ba.aux_rvalid ? ba.aux_rdata : ba.core_rdata;
            if (rq.size() == 0) begin
                n_bad++;
                $display("FAIL rvalid_unexpected: core_rvalid=%0b aux_rvalid=%0b data=0x%08h, required none",
                         ba.core_rvalid, ba.aux_rvalid, mdata);
            end else begin
                mr = rq.pop_front();
                if (ba.aux_rvalid !== mr.aux || ba.core_rvalid !== !mr.aux || mdata !== mr.data) begin
                    n_bad++;
                    $display("FAIL rdata: got core_rvalid=%0b aux_rvalid=%0b data=0x%08h, expected aux=%0b data=0x%08h",
                             ba.core_rvalid, ba.aux_rvalid, mdata, mr.aux, mr.data);
                end
            end
        end
        if (bp.core_gnt || bp.aux_gnt) begin
            n_vec++;
            if (pq.size() == 0) begin
                n_bad++;
                $display("FAIL pri_grant_unexpected: core_gnt=%0b aux_gnt=%0b, required no grant",
                         bp.core_gnt, bp.aux_gnt);
            end else begin
                mb = pq.pop_front();
                if (bp.aux_gnt !== mb || bp.core_gnt !== !mb) begin
                    n_bad++;
                    $display("FAIL pri_grant: got core=%0b aux=%0b, expected aux=%0b",
                             bp.core_gnt, bp.aux_gnt, mb);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        drv_core(1'b0, 1'b0, 32'h0, 32'h0);
        drv_aux(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        bp.core_req = 1'b0; bp.core_we = 1'b1; bp.core_addr = 32'h100; bp.core_wdata = 32'h1;
        bp.core_funct3 = 3'b010;
        bp.aux_req = 1'b0; bp.aux_we = 1'b1; bp.aux_addr = 32'h200; bp.aux_wdata = 32'h2;
        bp.aux_funct3 = 3'b010; bp.aux_lock = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[1] = 32'hDEAD_BEEF;

        // Reset state.
        step();
        chk("reset_flags", 32'({ba.core_gnt, ba.aux_gnt, ba.core_rvalid, ba.aux_rvalid, ba.mem_wren}), 32'h0);
        chk("reset_core_rdata", ba.core_rdata, 32'h0);
        chk("reset_aux_rdata", ba.aux_rdata, 32'h0);
        rst = 1'b0;

        // Reset mid-read: response is dropped.
        drv_core(1'b1, 1'b0, 32'h10, 32'h0);
        exp_gnt(1'b0, 1'b0, 32'h10, 32'h0);
        step();
        rst = 1'b1;
        drv_core(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_mid_read_rvalid", 32'(ba.core_rvalid), 32'h0);
        chk("rst_mid_read_rdata", ba.core_rdata, 32'h0);
        step();
        chk("rst_mid_read_gnt", 32'({ba.core_gnt, ba.aux_gnt, ba.core_rvalid}), 32'h0);
        rst = 1'b0;
        step();

        // Round-robin under continuous contention, core first after reset, back-to-back reads.
        drv_core(1'b1, 1'b0, 32'h20, 32'h0);
        drv_aux(1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            exp_gnt(i[0], 1'b0, i[0] ? 32'h24 : 32'h20, 32'h0);
            exp_rd(i[0], i[0] ? 32'h1000_0009 : 32'h1000_0008);
            step();
        end
        drv_aux(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Single core read with rdata hold afterwards.
        drv_core(1'b1, 1'b0, 32'h4, 32'h0);
        exp_gnt(1'b0, 1'b0, 32'h4, 32'h0);
        exp_rd(1'b0, 32'hDEAD_BEEF);
        step();
        drv_core(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("core_rdata_hold", ba.core_rdata, 32'hDEAD_BEEF);
        chk("aux_rdata_hold", ba.aux_rdata, 32'h1000_0009);

        // Locked aux write burst; core waits until lock drops.
        drv_aux(1'b1, 1'b1, 32'h40, 32'hB000_0000, 1'b1);
        exp_gnt(1'b1, 1'b1, 32'h40, 32'hB000_0000);
        step();
        for (int i = 1; i < 5; i++) begin
            drv_aux(1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1);
            drv_core(1'b1, 1'b0, 32'h44, 32'h0);
            exp_gnt(1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'hB000_0000 + 32'(i));
            step();
        end
        drv_aux(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        exp_gnt(1'b0, 1'b0, 32'h44, 32'h0);
        exp_rd(1'b0, 32'hB000_0001);
        step();
        drv_core(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Core write then aux read of the same word.
        drv_core(1'b1, 1'b1, 32'h30, 32'hCAFE_F00D);
        exp_gnt(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D);
        step();
        drv_core(1'b0, 1'b0, 32'h0, 32'h0);
        drv_aux(1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        exp_gnt(1'b1, 1'b0, 32'h30, 32'h0);
        exp_rd(1'b1, 32'hCAFE_F00D);
        step();
        drv_aux(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();

        // Aux priority with starvation guard MAX_WAIT=3.
        pq.push_back(1'b1); pq.push_back(1'b1); pq.push_back(1'b1); pq.push_back(1'b0);
        pq.push_back(1'b1); pq.push_back(1'b1); pq.push_back(1'b1); pq.push_back(1'b0);
        bp.core_req = 1'b1;
        bp.aux_req  = 1'b1;
        for (int i = 0; i < 8; i++) step();
        bp.core_req = 1'b0;
        bp.aux_req  = 1'b0;
        repeat (3) step();

        chk("grants_outstanding", 32'(gq.size()), 32'h0);
        chk("responses_outstanding", 32'(rq.size()), 32'h0);
        chk("pri_grants_outstanding", 32'(pq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
